// File: rtl/binary16_square.sv
// Squares an IEEE binary16 operand in a fixed four-stage pipeline.
// Negative inputs square to positive values. Subnormal inputs and underflows flush to zero.
module binary16_square #(
   parameter int ROUND_NEAREST = 1
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [15:0] n,
   input  logic        data_valid_in,
   output logic [15:0] result,
   output logic        data_valid_out,
   output logic        busy
);

   localparam int STAGES = 4;

   typedef enum logic [1:0] {
      CL_NORM,
      CL_ZERO,
      CL_INF,
      CL_NAN
   } cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [4:0] exp;
      logic [9:0] mant;
   } s1_t;

   typedef struct packed {
      cls_t        cls;
      logic [4:0]  exp;
      logic [21:0] prod;
   } s2_t;

   typedef struct packed {
      cls_t       cls;
      logic [7:0] e;     // signed unbiased-plus-bias exponent after rounding
      logic [9:0] mant;
   } s3_t;

   logic [STAGES:1] vld_pipe;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   s3_t             s3_d, s3_q;
   logic [15:0]     pack_d;

   // S1: unpack and classify
   always_comb begin
      s1_d.exp  = n[14:10];
      s1_d.mant = n[9:0];
      s1_d.cls  = CL_NORM;
      if (n[14:10] == 5'd0)
         s1_d.cls = CL_ZERO;
      else if (n[14:10] == 5'h1F)
         s1_d.cls = (n[9:0] == 10'd0) ? CL_INF : CL_NAN;
   end

   // S2: 11x11 significand product
   logic [10:0] sig;
   always_comb begin
      sig        = {1'b1, s1_q.mant};
      s2_d.cls   = s1_q.cls;
      s2_d.exp   = s1_q.exp;
      s2_d.prod  = 22'(sig) * 22'(sig);
   end

   // S3: normalize on P[21], then round
   logic [9:0]        m_raw;
   logic              guard, sticky, inc;
   logic [10:0]       m_rnd;
   logic signed [7:0] e_raw, e_fin;
   always_comb begin
      if (s2_q.prod[21]) begin
         m_raw  = s2_q.prod[20:11];
         guard  = s2_q.prod[10];
         sticky = |s2_q.prod[9:0];
         e_raw  = $signed({2'b00, s2_q.exp, 1'b0}) - 8'sd14;
      end else begin
         m_raw  = s2_q.prod[19:10];
         guard  = s2_q.prod[9];
         sticky = |s2_q.prod[8:0];
         e_raw  = $signed({2'b00, s2_q.exp, 1'b0}) - 8'sd15;
      end
      inc   = (ROUND_NEAREST != 0) && guard && (sticky || m_raw[0]);
      m_rnd = {1'b0, m_raw} + {10'd0, inc};
      // A carry out of the rounding step leaves m_rnd[9:0] at zero.
      e_fin = m_rnd[10] ? (e_raw + 8'sd1) : e_raw;
      s3_d.cls  = s2_q.cls;
      s3_d.mant = m_rnd[9:0];
      s3_d.e    = e_fin;
   end

   // S4: pack the result and handle special classes and range limits
   always_comb begin
      pack_d = {1'b0, s3_q.e[4:0], s3_q.mant};
      case (s3_q.cls)
         CL_ZERO: pack_d = 16'h0000;
         CL_INF:  pack_d = 16'h7C00;
         CL_NAN:  pack_d = 16'h7E00;
         default: begin
            if ($signed(s3_q.e) >= 8'sd31)
               pack_d = 16'h7C00;
            else if ($signed(s3_q.e) <= 8'sd0)
               pack_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         result   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], data_valid_in};
         if (data_valid_in) s1_q   <= s1_d;
         if (vld_pipe[1])   s2_q   <= s2_d;
         if (vld_pipe[2])   s3_q   <= s3_d;
         if (vld_pipe[3])   result <= pack_d;
      end
   end

   assign data_valid_out = vld_pipe[STAGES];
   assign busy           = |vld_pipe;

endmodule

// File: tb/tb_binary16_square.sv
// Directed checks of binary16_square with both rounding modes side by side.
module tb_binary16_square;

   logic        clk_in, rst, data_valid_in;
   logic [15:0] n;
   logic [15:0] result_rn, result_tz;
   logic        dvo_rn, dvo_tz, busy_rn, busy_tz;

   int checks   = 0;
   int failures = 0;
   int j;
   logic        exp_v;
   logic [15:0] last_rn, last_tz;

   // Throughput sequence; slot 4 is the bubble and its operand must be ignored.
   logic [15:0] tp_n  [9] = '{16'h4000, 16'h3E00, 16'hC200, 16'h3C00, 16'h7E01,
                              16'h3C01, 16'h3DFF, 16'h1C00, 16'hFC00};
   logic        tp_v  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [15:0] tp_rn [9] = '{16'h4400, 16'h4080, 16'h4880, 16'h3C00, 16'h0000,
                              16'h3C02, 16'h407F, 16'h0000, 16'h7C00};
   logic [15:0] tp_tz [9] = '{16'h4400, 16'h4080, 16'h4880, 16'h3C00, 16'h0000,
                              16'h3C02, 16'h407E, 16'h0000, 16'h7C00};

   binary16_square #(.ROUND_NEAREST(1)) dut_rn (
      .clk_in(clk_in), .rst(rst), .n(n), .data_valid_in(data_valid_in),
      .result(result_rn), .data_valid_out(dvo_rn), .busy(busy_rn)
   );

   binary16_square #(.ROUND_NEAREST(0)) dut_tz (
      .clk_in(clk_in), .rst(rst), .n(n), .data_valid_in(data_valid_in),
      .result(result_tz), .data_valid_out(dvo_tz), .busy(busy_tz)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // One operand, then idle; the result must appear after the fourth edge only.
   task automatic run_one(input string tag, input logic [15:0] v,
                          input logic [15:0] e_rn, input logic [15:0] e_tz);
      @(negedge clk_in);
      n = v;
      data_valid_in = 1'b1;
      @(posedge clk_in); #1;
      chk1({tag, "_busy"}, busy_rn, 1'b1);
      @(negedge clk_in);
      data_valid_in = 1'b0;
      n = 16'hFFFF;
      @(posedge clk_in);
      @(posedge clk_in); #1;
      chk1({tag, "_early"}, dvo_rn, 1'b0);
      @(posedge clk_in); #1;
      chk1({tag, "_vld_rn"}, dvo_rn, 1'b1);
      chk1({tag, "_vld_tz"}, dvo_tz, 1'b1);
      chk16({tag, "_rn"}, result_rn, e_rn);
      chk16({tag, "_tz"}, result_tz, e_tz);
      @(posedge clk_in); #1;
      chk1({tag, "_pulse"}, dvo_rn, 1'b0);
      chk16({tag, "_hold"}, result_rn, e_rn);
      chk1({tag, "_idle"}, busy_rn, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      n = 16'h0000;
      data_valid_in = 1'b0;
      #1;
      chk16("rst_result", result_rn, 16'h0000);
      chk1("rst_vld", dvo_rn, 1'b0);
      chk1("rst_busy", busy_rn, 1'b0);
      @(posedge clk_in);
      @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;

      run_one("two",       16'h4000, 16'h4400, 16'h4400);
      run_one("one_half",  16'h3E00, 16'h4080, 16'h4080);
      run_one("neg3",      16'hC200, 16'h4880, 16'h4880);
      run_one("zero",      16'h0000, 16'h0000, 16'h0000);
      run_one("subn",      16'h0001, 16'h0000, 16'h0000);
      run_one("ninf",      16'hFC00, 16'h7C00, 16'h7C00);
      run_one("nan",       16'h7E01, 16'h7E00, 16'h7E00);
      run_one("ovf",       16'h5C00, 16'h7C00, 16'h7C00);
      run_one("unf",       16'h1C00, 16'h0000, 16'h0000);
      run_one("one",       16'h3C00, 16'h3C00, 16'h3C00);
      run_one("rnd_exact", 16'h3C01, 16'h3C02, 16'h3C02);
      run_one("rnd_up",    16'h3DFF, 16'h407F, 16'h407E);
      // 1448^2 leaves a mantissa of all ones with guard set; RNE carries into the exponent.
      run_one("rnd_carry", 16'h3DA8, 16'h4000, 16'h3FFF);

      // Back-to-back stream with one bubble
      last_rn = 16'h4000;
      last_tz = 16'h3FFF;
      for (int t = 0; t < 13; t++) begin
         @(negedge clk_in);
         if (t < 9) begin
            n = tp_n[t];
            data_valid_in = tp_v[t];
         end else begin
            n = 16'h0000;
            data_valid_in = 1'b0;
         end
         @(posedge clk_in); #1;
         j = t - 3;
         exp_v = (j >= 0 && j < 9) ? tp_v[j] : 1'b0;
         if (exp_v) begin
            last_rn = tp_rn[j];
            last_tz = tp_tz[j];
         end
         chk1($sformatf("tp_vld%0d", t), dvo_rn, exp_v);
         chk16($sformatf("tp_rn%0d", t), result_rn, last_rn);
         chk16($sformatf("tp_tz%0d", t), result_tz, last_tz);
         chk1($sformatf("tp_busy%0d", t), busy_rn, (t <= 11));
      end

      // Reset with three operands in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         n = 16'h4000;
         data_valid_in = 1'b1;
         @(posedge clk_in);
      end
      @(negedge clk_in);
      data_valid_in = 1'b0;
      chk1("mid_busy", busy_rn, 1'b1);
      rst = 1'b1;
      #1;
      chk16("mid_rst_result", result_rn, 16'h0000);
      chk1("mid_rst_vld", dvo_rn, 1'b0);
      chk1("mid_rst_busy", busy_rn, 1'b0);
      @(posedge clk_in);
      @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_in); #1;
         chk1($sformatf("flushed%0d", k), dvo_rn, 1'b0);
      end
      run_one("post_rst", 16'h3E00, 16'h4080, 16'h4080);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
